alu_multibyte_seq: RTL and testbench

//  Sequences the shared 8-bit ALU (SEL/A/B/CIN in, RES/C/Z out) to run NBYTES-wide ops, one byte per clock, LSB first.

---
 rtl/alu_multibyte_seq_if.sv | 38 +++
 rtl/alu_multibyte_seq.sv | 134 +++++++++++++
 tb/tb_alu_multibyte_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_multibyte_seq_if.sv
// Bundle between the control unit, the multibyte sequencer and the shared 8-bit ALU.
// The slave side is the sequencer; the master side is the control unit plus the ALU.
interface alu_multibyte_seq_if #(
    parameter int NBYTES = 2
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [3:0]   op;
    logic         cin;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         z_out;
    logic         err;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [3:0]   alu_sel;
    logic [7:0]   alu_res;
    logic         alu_c;
    logic         alu_z;

    modport slave (
        input  start, op, cin, opa, opb, alu_res, alu_c, alu_z,
        output busy, done, result, c_out, z_out, err,
               alu_a, alu_b, alu_cin, alu_sel
    );

    modport master (
        output start, op, cin, opa, opb, alu_res, alu_c, alu_z,
        input  busy, done, result, c_out, z_out, err,
               alu_a, alu_b, alu_cin, alu_sel
    );
endinterface

// File: rtl/alu_multibyte_seq.sv
// Runs NBYTES-wide operations on a shared 8-bit ALU, one byte per clock, LSB first,
// chaining carry/borrow between bytes and accumulating the zero flag.
module alu_multibyte_seq #(
    parameter int NBYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_multibyte_seq_if.slave   bus
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_reg, state_next;
    logic [IDXW-1:0] idx_reg;
    logic [3:0]      op_reg;
    logic            cin_reg;
    logic [W-1:0]    opa_reg;
    logic [W-1:0]    opb_reg;
    logic [W-1:0]    work_reg;
    logic            cy_reg;
    logic            zacc_reg;
    logic [W-1:0]    result_reg;
    logic            c_reg;
    logic            z_reg;
    logic            err_reg;

    logic [7:0]      opa_byte [NBYTES];
    logic [7:0]      opb_byte [NBYTES];
    logic [W-1:0]    final_res;
    logic            op_legal;
    logic            last_byte;
    logic            writes_result;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign opa_byte[gi] = opa_reg[8*gi +: 8];
            assign opb_byte[gi] = opb_reg[8*gi +: 8];
            // The top byte comes straight from the ALU on the final RUN edge.
            assign final_res[8*gi +: 8] = (gi == NBYTES - 1) ? bus.alu_res : work_reg[8*gi +: 8];
        end
    endgenerate

    assign op_legal      = (bus.op <= 4'd8) || (bus.op == 4'd14);
    assign last_byte     = (idx_reg == IDXW'(NBYTES - 1));
    assign writes_result = (op_reg != 4'd4) && (op_reg != 4'd8);

    // An illegal op spends one RUN cycle without touching the ALU so that DONE
    // arrives one cycle after acceptance, regardless of NBYTES.
    always_comb begin
        state_next   = state_reg;
        bus.alu_a    = 8'd0;
        bus.alu_b    = 8'd0;
        bus.alu_cin  = 1'b0;
        bus.alu_sel  = 4'd15;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                if (err_reg) begin
                    state_next = FIN;
                end else begin
                    bus.alu_a = opa_byte[idx_reg];
                    bus.alu_b = opb_byte[idx_reg];
                    if (idx_reg == '0) begin
                        bus.alu_sel = op_reg;
                        bus.alu_cin = cin_reg;
                    end else begin
                        case (op_reg)
                            4'd0, 4'd1:       bus.alu_sel = 4'd1;
                            4'd2, 4'd3, 4'd4: bus.alu_sel = 4'd3;
                            default:          bus.alu_sel = op_reg;
                        endcase
                        bus.alu_cin = cy_reg;
                    end
                    if (last_byte) state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            op_reg     <= 4'd0;
            cin_reg    <= 1'b0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            work_reg   <= '0;
            cy_reg     <= 1'b0;
            zacc_reg   <= 1'b0;
            result_reg <= '0;
            c_reg      <= 1'b0;
            z_reg      <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                err_reg  <= !op_legal;
                op_reg   <= bus.op;
                cin_reg  <= bus.cin;
                opa_reg  <= bus.opa;
                opb_reg  <= bus.opb;
                idx_reg  <= '0;
                zacc_reg <= 1'b1;
            end
            if (state_reg == RUN && !err_reg) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_reg == IDXW'(i)) work_reg[8*i +: 8] <= bus.alu_res;
                end
                cy_reg   <= bus.alu_c;
                zacc_reg <= zacc_reg & bus.alu_z;
                idx_reg  <= idx_reg + 1'b1;
                if (last_byte) begin
                    if (writes_result) result_reg <= final_res;
                    c_reg <= bus.alu_c;
                    z_reg <= zacc_reg & bus.alu_z;
                end
            end
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = (state_reg == FIN);
    assign bus.result = result_reg;
    assign bus.c_out  = c_reg;
    assign bus.z_out  = z_reg;
    assign bus.err    = err_reg;
endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Self-checking bench for alu_multibyte_seq (NBYTES=2): directed table, random ops
// against a whole-word reference model, and start-while-busy / mid-op reset sequences.
module tb_alu_multibyte_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_multibyte_seq_if #(.NBYTES(2)) bus ();

    alu_multibyte_seq #(.NBYTES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU the sequencer drives
    logic [8:0] alu_full;
    always_comb begin
        alu_full = 9'd0;
        case (bus.alu_sel)
            4'd0:  alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'd1:  alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
            4'd2:  alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            4'd3:  alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_cin};
            4'd4:  alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            4'd5:  alu_full = {1'b0, bus.alu_a & bus.alu_b};
            4'd6:  alu_full = {1'b0, bus.alu_a | bus.alu_b};
            4'd7:  alu_full = {1'b0, bus.alu_a ^ bus.alu_b};
            4'd8:  alu_full = {1'b0, bus.alu_a & bus.alu_b};
            4'd14: alu_full = {1'b0, bus.alu_b};
            default: alu_full = 9'd0;
        endcase
    end
    assign bus.alu_res = alu_full[7:0];
    assign bus.alu_c   = alu_full[8];
    assign bus.alu_z   = (alu_full[7:0] == 8'd0);

    // Whole-word reference state
    logic [15:0] m_result = 16'd0;
    logic        m_c = 1'b0;
    logic        m_z = 1'b0;
    logic        m_err = 1'b0;

    task automatic model_op(input logic [3:0] op, input logic ci, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] full;
        full = 17'd0;
        if (!((op <= 4'd8) || (op == 4'd14))) begin
            m_err = 1'b1;
            return;
        end
        m_err = 1'b0;
        case (op)
            4'd0:    full = {1'b0, a} + {1'b0, b};
            4'd1:    full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            4'd2:    full = {1'b0, a} - {1'b0, b};
            4'd3:    full = {1'b0, a} - {1'b0, b} - {16'd0, ci};
            4'd4:    full = {1'b0, a} - {1'b0, b};
            4'd5:    full = {1'b0, a & b};
            4'd6:    full = {1'b0, a | b};
            4'd7:    full = {1'b0, a ^ b};
            4'd8:    full = {1'b0, a & b};
            default: full = {1'b0, b};
        endcase
        m_c = full[16];
        m_z = (full[15:0] == 16'd0);
        if (op != 4'd4 && op != 4'd8) m_result = full[15:0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op and measure cycles from the START cycle to DONE
    task automatic run_op(input logic [3:0] op, input logic ci, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        bool_wait: begin end
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.cin = ci; bus.opa = a; bus.opb = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
        check("idle_sel", {28'd0, bus.alu_sel}, 32'd15);
        $display("[TB] op=%0d cin=%0d a=%04h b=%04h -> res=%04h c=%0d z=%0d err=%0d lat=%0d",
                 op, ci, a, b, bus.result, bus.c_out, bus.z_out, bus.err, lat);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        ci;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int done_cnt;
        logic [3:0] rop;

        vecs[0] = '{4'd0,  1'b0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd0,  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'd1,  1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd2,  1'b0, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd2,  1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'd4,  1'b0, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'd8,  1'b0, 16'hF000, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'd9,  1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{4'd0,  1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0; bus.op = 4'd0; bus.cin = 1'b0; bus.opa = 16'd0; bus.opb = 16'd0;
        #12;
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_done",   {31'd0, bus.done},   32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        check("rst_flags",  {29'd0, bus.c_out, bus.z_out, bus.err}, 32'd0);
        check("rst_alu",    {15'd0, bus.alu_a, bus.alu_b, bus.alu_cin}, 32'd0);
        check("rst_sel",    {28'd0, bus.alu_sel}, 32'd15);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].ci, vecs[i].a, vecs[i].b, lat);
            model_op(vecs[i].op, vecs[i].ci, vecs[i].a, vecs[i].b);
            check("vec_result", {16'd0, bus.result}, {16'd0, vecs[i].res});
            check("vec_c",      {31'd0, bus.c_out},  {31'd0, vecs[i].c});
            check("vec_z",      {31'd0, bus.z_out},  {31'd0, vecs[i].z});
            check("vec_err",    {31'd0, bus.err},    {31'd0, vecs[i].err});
            check("vec_latency", lat, vecs[i].err ? 32'd2 : 32'd3);
        end

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, 1'($urandom), 16'($urandom), 16'($urandom), lat);
            model_op(rop, bus.cin, bus.opa, bus.opb);
            check("rnd_result", {16'd0, bus.result}, {16'd0, m_result});
            check("rnd_flags",  {29'd0, bus.c_out, bus.z_out, bus.err}, {29'd0, m_c, m_z, m_err});
            check("rnd_latency", lat, m_err ? 32'd2 : 32'd3);
        end

        // START held high during RUN must be ignored
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.cin = 1'b0; bus.opa = 16'h1111; bus.opb = 16'h2222;
        @(posedge clk);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        model_op(4'd0, 1'b0, 16'h1111, 16'h2222);
        check("busy_start_dones", done_cnt, 32'd1);
        check("busy_start_result", {16'd0, bus.result}, {16'd0, m_result});
        $display("[TB] start-while-busy: dones=%0d res=%04h", done_cnt, bus.result);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd6; bus.opa = 16'h00F0; bus.opb = 16'h0F00;
        @(posedge clk);
        #1 bus.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",   {31'd0, bus.busy},   32'd0);
        check("mid_rst_result", {16'd0, bus.result}, 32'd0);
        check("mid_rst_flags",  {29'd0, bus.c_out, bus.z_out, bus.err}, 32'd0);
        check("mid_rst_alu",    {15'd0, bus.alu_a, bus.alu_b, bus.alu_cin}, 32'd0);
        check("mid_rst_sel",    {28'd0, bus.alu_sel}, 32'd15);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 32'd0);
        $display("[TB] mid-run reset: result=%04h busy=%0d", bus.result, bus.busy);
        m_result = 16'd0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;

        run_op(4'd3, 1'b1, 16'h0200, 16'h0100, lat);
        model_op(4'd3, 1'b1, 16'h0200, 16'h0100);
        check("post_rst_result", {16'd0, bus.result}, {16'd0, m_result});
        check("post_rst_flags",  {29'd0, bus.c_out, bus.z_out, bus.err}, {29'd0, m_c, m_z, m_err});
        check("post_rst_latency", lat, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
